// File: rtl/dm_wb_cache_pkg.sv
// Shared types and line geometry for the direct-mapped write-back cache.
package dm_wb_cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      WB,
      LD
   } state_e;

   localparam int LINE_BITS      = 256;
   localparam int OFFSET_BITS    = 5;
   localparam int WORDS_PER_LINE = 8;

endpackage

// File: rtl/dm_wb_cache_merge.sv
// Byte-masked merge of one 32-bit word into a 256-bit cache line at a word index.
module dm_wb_cache_merge
   import dm_wb_cache_pkg::*;
(
   input  logic [LINE_BITS-1:0] line_i,
   input  logic [31:0]          word_i,
   input  logic [3:0]           wmask_i,
   input  logic [2:0]           wordIdx_i,
   output logic [LINE_BITS-1:0] line_o
);

   always_comb begin
      line_o = line_i;
      for (int b = 0; b < 4; b++) begin
         if (wmask_i[b]) begin
            line_o[int'(wordIdx_i) * 32 + b * 8 +: 8] = word_i[b * 8 +: 8];
         end
      end
   end

endmodule

// File: rtl/dm_wb_cache.sv
// Direct-mapped write-back write-allocate cache between a 32-bit core port and a 256-bit line port.
// Defining DM_WB_CACHE_PERF_EN adds the hit_count and miss_count outputs.
module dm_wb_cache #(
   parameter int NUM_SETS = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  ufp_addr,
   input  logic [3:0]   ufp_rmask,
   input  logic [3:0]   ufp_wmask,
   input  logic [31:0]  ufp_wdata,
   output logic [31:0]  ufp_rdata,
   output logic         ufp_resp,
   output logic [31:0]  dfp_addr,
   output logic         dfp_read,
   output logic         dfp_write,
   output logic [255:0] dfp_wdata,
   input  logic [255:0] dfp_rdata,
   input  logic         dfp_resp
`ifdef DM_WB_CACHE_PERF_EN
   ,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
`endif
);

   import dm_wb_cache_pkg::*;

   localparam int IDX      = $clog2(NUM_SETS);
   localparam int TAG_BITS = 32 - OFFSET_BITS - IDX;

   state_e state_q, state_d;

   logic [LINE_BITS-1:0] data_q [NUM_SETS];
   logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
   logic [NUM_SETS-1:0]  valid_q;
   logic [NUM_SETS-1:0]  dirty_q;

   logic [IDX-1:0]       idx;
   logic [TAG_BITS-1:0]  reqTag;
   logic [2:0]           wordSel;
   logic                 hit;
   logic                 isWrite;
   logic [LINE_BITS-1:0] curLine;
   logic [LINE_BITS-1:0] mergedLine;
   logic                 unusedByteOffset;

   assign idx              = ufp_addr[OFFSET_BITS+IDX-1:OFFSET_BITS];
   assign reqTag           = ufp_addr[31:OFFSET_BITS+IDX];
   assign wordSel          = ufp_addr[4:2];
   assign unusedByteOffset = ^ufp_addr[1:0];
   assign isWrite          = |ufp_wmask;
   assign curLine          = data_q[idx];
   assign hit              = valid_q[idx] && (tag_q[idx] == reqTag);
   assign ufp_rdata        = curLine[{wordSel, 5'b0} +: 32];
   assign dfp_wdata        = curLine;

   dm_wb_cache_merge u_merge (
      .line_i    (curLine),
      .word_i    (ufp_wdata),
      .wmask_i   (ufp_wmask),
      .wordIdx_i (wordSel),
      .line_o    (mergedLine)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      ufp_resp  = 1'b0;
      dfp_read  = 1'b0;
      dfp_write = 1'b0;
      dfp_addr  = {ufp_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      unique case (state_q)
         IDLE: begin
            if ((|ufp_rmask) || isWrite) state_d = CHECK;
         end
         CHECK: begin
            if (hit) begin
               ufp_resp = 1'b1;
               state_d  = IDLE;
            end else if (valid_q[idx] && dirty_q[idx]) begin
               state_d = WB;
            end else begin
               state_d = LD;
            end
         end
         WB: begin
            dfp_write = 1'b1;
            dfp_addr  = {tag_q[idx], idx, {OFFSET_BITS{1'b0}}};
            if (dfp_resp) state_d = LD;
         end
         LD: begin
            dfp_read = 1'b1;
            if (dfp_resp) state_d = CHECK;
         end
         default: state_d = IDLE;
      endcase
      // A stale WB/LD state must not leak a request while reset is asserted.
      if (rst) begin
         ufp_resp  = 1'b0;
         dfp_read  = 1'b0;
         dfp_write = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == LD && dfp_resp) begin
            data_q[idx] <= dfp_rdata;
            tag_q[idx]  <= reqTag;
         end else if (state_q == CHECK && hit && isWrite) begin
            data_q[idx] <= mergedLine;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (state_q == LD && dfp_resp) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end else if (state_q == WB && dfp_resp) begin
            dirty_q[idx] <= 1'b0;
         end else if (state_q == CHECK && hit && isWrite) begin
            dirty_q[idx] <= 1'b1;
         end
      end
   end

`ifdef DM_WB_CACHE_PERF_EN
   logic        fromLd_q;
   logic [31:0] hitCount_q;
   logic [31:0] missCount_q;

   // The CHECK that follows a refill always hits and is not a real hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         fromLd_q    <= 1'b0;
         hitCount_q  <= '0;
         missCount_q <= '0;
      end else begin
         fromLd_q <= (state_q == LD) && dfp_resp;
         if (state_q == CHECK) begin
            if (hit && !fromLd_q) hitCount_q  <= hitCount_q + 32'd1;
            else if (!hit)        missCount_q <= missCount_q + 32'd1;
         end
      end
   end

   assign hit_count  = hitCount_q;
   assign miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_dm_wb_cache.sv
// Self-checking bench for dm_wb_cache: directed test-plan cases plus randomized traffic against a behavioural model.
module tb_dm_wb_cache;

   localparam int SETS = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  ufp_addr;
   logic [3:0]   ufp_rmask;
   logic [3:0]   ufp_wmask;
   logic [31:0]  ufp_wdata;
   logic [31:0]  ufp_rdata;
   logic         ufp_resp;
   logic [31:0]  dfp_addr;
   logic         dfp_read;
   logic         dfp_write;
   logic [255:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
`ifdef DM_WB_CACHE_PERF_EN
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;
`endif

   dm_wb_cache #(.NUM_SETS(SETS)) dut (
      .clk       (clk),
      .rst       (rst),
      .ufp_addr  (ufp_addr),
      .ufp_rmask (ufp_rmask),
      .ufp_wmask (ufp_wmask),
      .ufp_wdata (ufp_wdata),
      .ufp_rdata (ufp_rdata),
      .ufp_resp  (ufp_resp),
      .dfp_addr  (dfp_addr),
      .dfp_read  (dfp_read),
      .dfp_write (dfp_write),
      .dfp_wdata (dfp_wdata),
      .dfp_rdata (dfp_rdata),
      .dfp_resp  (dfp_resp)
`ifdef DM_WB_CACHE_PERF_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Backing memory (line number -> line) and core-visible word values since the last reset.
   logic [255:0] mem  [int unsigned];
   logic [31:0]  gold [int unsigned];

   // Which line the cache is expected to hold per set.
   bit          mValid [SETS];
   bit          mDirty [SETS];
   int unsigned mTag   [SETS];
   int          expHits;
   int          expMisses;

   logic [31:0]  lastRdata;
   logic [31:0]  lastRdAddr;
   logic [31:0]  lastWrAddr;
   logic [255:0] lastWrData;
   int           lastNRd;
   int           lastNWr;
   int           lastCyc;

   task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] initWord(input int unsigned wa);
      if (wa == 32'h409) return 32'hDEAD_BEEF;
      return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] memWord(input int unsigned wa);
      logic [255:0] ln;
      if (!mem.exists(wa >> 3)) return initWord(wa);
      ln = mem[wa >> 3];
      return ln[(wa % 8) * 32 +: 32];
   endfunction

   function automatic logic [31:0] goldWord(input int unsigned wa);
      if (gold.exists(wa)) return gold[wa];
      return memWord(wa);
   endfunction

   function automatic logic [255:0] memLine(input int unsigned lineNo);
      logic [255:0] ln;
      for (int j = 0; j < 8; j++) ln[j * 32 +: 32] = memWord(lineNo * 8 + j);
      return ln;
   endfunction

   function automatic logic [255:0] goldLine(input int unsigned lineNo);
      logic [255:0] ln;
      for (int j = 0; j < 8; j++) ln[j * 32 +: 32] = goldWord(lineNo * 8 + j);
      return ln;
   endfunction

   task automatic modelReset();
      for (int s = 0; s < SETS; s++) begin
         mValid[s] = 1'b0;
         mDirty[s] = 1'b0;
      end
      gold.delete();
      expHits   = 0;
      expMisses = 0;
   endtask

   // Issues one request, plays the line memory with random latency, and checks the outcome.
   task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                                input logic [31:0] wd);
      int unsigned  lineNo, set, tag, wa;
      bit           expHit, expWb, done, busy, both;
      logic [31:0]  expWord, w;
      logic [255:0] expWbLine;
      int           cyc, cnt, lat, busySum;

      wa      = addr >> 2;
      lineNo  = addr >> 5;
      set     = lineNo % SETS;
      tag     = lineNo / SETS;
      expHit  = mValid[set] && (mTag[set] == tag);
      expWb   = !expHit && mValid[set] && mDirty[set];
      expWbLine = goldLine(mTag[set] * SETS + set);
      expWord = goldWord(wa);

      ufp_addr  = addr;
      ufp_rmask = rm;
      ufp_wmask = wm;
      ufp_wdata = wd;
      cyc = 0; cnt = 0; lat = 0; busySum = 0;
      done = 0; busy = 0; both = 0;
      lastNRd = 0; lastNWr = 0;
      lastRdAddr = '0; lastWrAddr = '0; lastWrData = '0; lastRdata = '0;
      while (!done && cyc < 100) begin
         @(posedge clk); #1;
         dfp_resp = 1'b0;
         cyc++;
         if (dfp_read && dfp_write) both = 1;
         if (ufp_resp) begin
            lastRdata = ufp_rdata;
            done      = 1;
         end else if (dfp_read || dfp_write) begin
            if (!busy) begin
               busy = 1;
               cnt  = 0;
               lat  = $urandom_range(0, 3);
               busySum += lat + 1;
               if (dfp_write) begin
                  lastNWr++;
                  lastWrAddr = dfp_addr;
                  lastWrData = dfp_wdata;
               end else begin
                  lastNRd++;
                  lastRdAddr = dfp_addr;
               end
            end
            if (dfp_read) dfp_rdata = memLine(dfp_addr >> 5);
            if (cnt == lat) begin
               dfp_resp = 1'b1;
               busy     = 0;
               if (dfp_write) mem[dfp_addr >> 5] = dfp_wdata;
            end else begin
               cnt++;
            end
         end
      end
      lastCyc = cyc;
      checkOutput("resp_seen", 256'(done), 256'd1);
      if (!done) begin
         $display("[TB] FAIL timeout at addr %h", addr);
         $fatal(1, "[TB] request never completed");
      end
      @(posedge clk); #1;
      ufp_rmask = '0;
      ufp_wmask = '0;

      checkOutput("no_both_dfp", 256'(both), 256'd0);
      checkOutput("latency", 256'(cyc), expHit ? 256'd1 : 256'(2 + busySum));
      checkOutput("n_write", 256'(lastNWr), 256'(expWb));
      checkOutput("n_read", 256'(lastNRd), expHit ? 256'd0 : 256'd1);
      if (expWb) begin
         checkOutput("wb_addr", 256'(lastWrAddr), 256'((mTag[set] * SETS + set) << 5));
         checkOutput("wb_data", lastWrData, expWbLine);
      end
      if (!expHit) checkOutput("ld_addr", 256'(lastRdAddr), 256'(lineNo << 5));
      if (rm != 0) checkOutput("rdata", 256'(lastRdata), 256'(expWord));

      if (expHit) expHits++;
      else        expMisses++;
      if (!expHit) mDirty[set] = 1'b0;
      mValid[set] = 1'b1;
      mTag[set]   = tag;
      if (wm != 0) begin
         w = expWord;
         for (int b = 0; b < 4; b++) if (wm[b]) w[b * 8 +: 8] = wd[b * 8 +: 8];
         gold[wa]    = w;
         mDirty[set] = 1'b1;
      end
   endtask

   initial begin
      bit          seen;
      logic [31:0] a;
      int unsigned lineNo;

      rst       = 1'b1;
      ufp_addr  = '0;
      ufp_rmask = '0;
      ufp_wmask = '0;
      ufp_wdata = '0;
      dfp_rdata = '0;
      dfp_resp  = 1'b0;
      modelReset();

      @(posedge clk);
      @(posedge clk); #1;
      checkOutput("rst_ufp_resp", 256'(ufp_resp), 256'd0);
      checkOutput("rst_dfp_read", 256'(dfp_read), 256'd0);
      checkOutput("rst_dfp_write", 256'(dfp_write), 256'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("post_rst_resp", 256'(ufp_resp), 256'd0);
      checkOutput("post_rst_dfp", 256'({dfp_read, dfp_write}), 256'd0);

      applyStimulus(32'h0000_1024, 4'hF, 4'h0, '0);
      checkOutput("cold_ld_addr", 256'(lastRdAddr), 256'h1020);
      checkOutput("cold_rdata", 256'(lastRdata), 256'hDEAD_BEEF);
      applyStimulus(32'h0000_1024, 4'hF, 4'h0, '0);
      checkOutput("hit_latency", 256'(lastCyc), 256'd1);

      applyStimulus(32'h0000_1024, 4'h0, 4'b0101, 32'h1122_3344);
      checkOutput("whit_no_dfp", 256'(lastNRd + lastNWr), 256'd0);
      applyStimulus(32'h0000_1024, 4'hF, 4'h0, '0);
      checkOutput("merged_rdata", 256'(lastRdata), 256'hDE22_BE44);

      applyStimulus(32'h0000_1224, 4'hF, 4'h0, '0);
      checkOutput("evict_wb_addr", 256'(lastWrAddr), 256'h1020);
      checkOutput("evict_ld_addr", 256'(lastRdAddr), 256'h1220);

      applyStimulus(32'h0000_2000, 4'hF, 4'h0, '0);
      applyStimulus(32'h0000_2200, 4'hF, 4'h0, '0);
      checkOutput("clean_no_wb", 256'(lastNWr), 256'd0);
      checkOutput("clean_ld_addr", 256'(lastRdAddr), 256'h2200);

      ufp_addr  = 32'h0000_3000;
      ufp_rmask = 4'hF;
      seen      = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk); #1;
         if (dfp_read) seen = 1;
      end
      checkOutput("midld_seen", 256'(seen), 256'd1);
      rst = 1'b1;
      #1;
      checkOutput("midld_rst_comb", 256'(dfp_read), 256'd0);
      @(posedge clk); #1;
      checkOutput("midld_rst_read", 256'(dfp_read), 256'd0);
      ufp_rmask = '0;
      rst       = 1'b0;
      modelReset();
      @(posedge clk); #1;
      checkOutput("midld_after", 256'({dfp_read, dfp_write, ufp_resp}), 256'd0);
      applyStimulus(32'h0000_3000, 4'hF, 4'h0, '0);
      checkOutput("midld_remiss", 256'(lastNRd), 256'd1);

      for (int n = 0; n < 150; n++) begin
         lineNo = (32'h40 + $urandom_range(0, 2)) * SETS + $urandom_range(0, 3);
         a = 32'(lineNo << 5) | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            applyStimulus(a, 4'($urandom_range(1, 15)), 4'h0, '0);
         else
            applyStimulus(a, 4'h0, 4'($urandom_range(1, 15)), $urandom);
      end

`ifdef DM_WB_CACHE_PERF_EN
      checkOutput("hit_count", 256'(hit_count), 256'(expHits));
      checkOutput("miss_count", 256'(miss_count), 256'(expMisses));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
